// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared widths, frame geometry and the interleaved read
//                address helper for the stage-2 ping-pong reorder buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

   localparam int FFT_I_WIDTH    = 24;  // input sample width (signed)
   localparam int FFT_O_WIDTH    = 16;  // output sample width (signed)
   localparam int FFT_DATA_WIDTH = 16;  // lanes per vector
   localparam int FFT_NUM_VEC    = 32;  // vectors per frame
   localparam int FFT_SHIFT      = 8;   // rounding shift before saturation
   localparam int ADDR_W         = $clog2(FFT_NUM_VEC);

   typedef logic [ADDR_W-1:0] vec_addr_t;

   // Maps read count 0,1,2,3,... to vector 0,N/2,1,N/2+1,... so that the
   // radix-2 partners k and k+N/2 leave the buffer on adjacent cycles.
   function automatic vec_addr_t il_addr(input vec_addr_t cnt);
      return {cnt[0], cnt[ADDR_W-1:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/round_sat_lane.sv
`default_nettype none
// ============================================================================
//  Module      : round_sat_lane
//  Description : Combinational round-half-up by SHIFT followed by signed
//                saturation from I_WIDTH to O_WIDTH; flags saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module round_sat_lane #(
   parameter int I_WIDTH = 24,
   parameter int O_WIDTH = 16,
   parameter int SHIFT   = 8
) (
   input  logic signed [I_WIDTH-1:0] din,
   output logic signed [O_WIDTH-1:0] dout,
   output logic                      sat
);

   // One extra bit keeps the rounding add from overflowing at full scale.
   localparam logic signed [I_WIDTH:0] HALF  = (I_WIDTH+1)'(1) <<< (SHIFT-1);
   localparam logic signed [I_WIDTH:0] MAX_V = (I_WIDTH+1)'((1 << (O_WIDTH-1)) - 1);
   localparam logic signed [I_WIDTH:0] MIN_V = ~MAX_V;

   logic signed [I_WIDTH:0] sum;
   logic signed [I_WIDTH:0] shifted;

   // Round half up, arithmetic shift, then clamp to the output range.
   always_comb begin
      sum     = $signed({din[I_WIDTH-1], din}) + HALF;
      shifted = sum >>> SHIFT;
      sat     = 1'b0;
      dout    = shifted[O_WIDTH-1:0];
      if (shifted > MAX_V) begin
         dout = MAX_V[O_WIDTH-1:0];
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         dout = MIN_V[O_WIDTH-1:0];
         sat  = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pingpong_reorder_2_0.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_reorder_2_0
//  Description : Ping-pong frame buffer between FFT stage 1 and stage 2.
//                Captures NUM_VEC vectors per frame, replays them in the
//                interleaved order 0,N/2,1,N/2+1,... and rounds/saturates
//                every lane to O_WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module pingpong_reorder_2_0
   import fft_pkg::*;
#(
   parameter int I_WIDTH    = FFT_I_WIDTH,
   parameter int O_WIDTH    = FFT_O_WIDTH,
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int NUM_VEC    = FFT_NUM_VEC,
   parameter int SHIFT      = FFT_SHIFT
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                din_valid,
   input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]  din_re,
   input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]  din_im,
   output logic [DATA_WIDTH-1:0][O_WIDTH-1:0]  dout_re,
   output logic [DATA_WIDTH-1:0][O_WIDTH-1:0]  dout_im,
   output logic                                dout_valid,
   output logic                                dout_sof,
   output logic                                dout_sat
);

   localparam int AW = $clog2(NUM_VEC);
   localparam logic [AW-1:0] LAST = AW'(NUM_VEC - 1);

   // Write side
   logic [AW-1:0] wr_cnt;
   logic          wr_bank;
   logic          frame_close;

   // Read side
   logic [AW-1:0] rd_cnt;
   logic [AW-1:0] rd_addr;
   logic          rd_bank;
   logic          rd_active;

   // Storage: both banks in one array, bank select is the address MSB.
   logic [DATA_WIDTH-1:0][I_WIDTH-1:0] mem_re [2*NUM_VEC];
   logic [DATA_WIDTH-1:0][I_WIDTH-1:0] mem_im [2*NUM_VEC];

   logic [DATA_WIDTH-1:0][I_WIDTH-1:0] rd_re;
   logic [DATA_WIDTH-1:0][I_WIDTH-1:0] rd_im;
   logic [DATA_WIDTH-1:0][O_WIDTH-1:0] rs_re;
   logic [DATA_WIDTH-1:0][O_WIDTH-1:0] rs_im;
   logic [DATA_WIDTH-1:0]              sat_re;
   logic [DATA_WIDTH-1:0]              sat_im;

   assign frame_close = din_valid && (wr_cnt == LAST);

   // Interleaved read address; the package helper covers the default geometry.
   if (AW == ADDR_W) begin : g_pkg_addr
      assign rd_addr = il_addr(rd_cnt);
   end else begin : g_local_addr
      assign rd_addr = {rd_cnt[0], rd_cnt[AW-1:1]};
   end

   // Write counter / bank toggle and read sequencing. A frame close always
   // (re)starts the read at count 0, which also covers the back-to-back
   // case where the previous readout wraps on the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         rd_cnt    <= '0;
         rd_bank   <= 1'b0;
         rd_active <= 1'b0;
      end else begin
         if (din_valid) begin
            wr_cnt <= wr_cnt + AW'(1);
         end
         if (frame_close) begin
            wr_bank   <= ~wr_bank;
            rd_bank   <= wr_bank;
            rd_cnt    <= '0;
            rd_active <= 1'b1;
         end else if (rd_active) begin
            rd_cnt <= rd_cnt + AW'(1);
            if (rd_cnt == LAST) begin
               rd_active <= 1'b0;
            end
         end
      end
   end

   // Frame storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (din_valid) begin
         mem_re[{wr_bank, wr_cnt}] <= din_re;
         mem_im[{wr_bank, wr_cnt}] <= din_im;
      end
   end

   assign rd_re = mem_re[{rd_bank, rd_addr}];
   assign rd_im = mem_im[{rd_bank, rd_addr}];

   for (genvar l = 0; l < DATA_WIDTH; l++) begin : g_lane
      round_sat_lane #(
         .I_WIDTH (I_WIDTH),
         .O_WIDTH (O_WIDTH),
         .SHIFT   (SHIFT)
      ) u_rs_re (
         .din  (rd_re[l]),
         .dout (rs_re[l]),
         .sat  (sat_re[l])
      );

      round_sat_lane #(
         .I_WIDTH (I_WIDTH),
         .O_WIDTH (O_WIDTH),
         .SHIFT   (SHIFT)
      ) u_rs_im (
         .din  (rd_im[l]),
         .dout (rs_im[l]),
         .sat  (sat_im[l])
      );
   end

   // Output register: data holds while idle, flags follow the read stream.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_re    <= '0;
         dout_im    <= '0;
         dout_valid <= 1'b0;
         dout_sof   <= 1'b0;
         dout_sat   <= 1'b0;
      end else begin
         dout_valid <= rd_active;
         dout_sof   <= rd_active && (rd_cnt == '0);
         dout_sat   <= rd_active && ((|sat_re) || (|sat_im));
         if (rd_active) begin
            dout_re <= rs_re;
            dout_im <= rs_im;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_reorder_2_0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pingpong_reorder_2_0
//  Description : Self-checking bench for pingpong_reorder_2_0: reorder order,
//                latency, back-to-back frames, input gaps, rounding and
//                saturation, and asynchronous reset mid-frame / mid-readout.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pingpong_reorder_2_0;

   localparam int IW = 24;
   localparam int OW = 16;
   localparam int DW = 16;
   localparam int NV = 32;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   din_valid = 1'b0;
   logic [DW-1:0][IW-1:0]  din_re = '0;
   logic [DW-1:0][IW-1:0]  din_im = '0;
   logic [DW-1:0][OW-1:0]  dout_re;
   logic [DW-1:0][OW-1:0]  dout_im;
   logic                   dout_valid;
   logic                   dout_sof;
   logic                   dout_sat;

   int n_cmp   = 0;
   int n_bad   = 0;
   int hold_re = 0;
   int hold_im = 0;

   typedef struct {
      int a;    // value on every real lane of vector 0
      int b;    // value on every imag lane of vector 0
      int ya;   // expected real output
      int yb;   // expected imag output
      int sat;  // expected dout_sat
   } rs_vec_t;

   rs_vec_t tab[7];

   always #5 clk = ~clk;

   pingpong_reorder_2_0 dut (
      .clk        (clk),
      .rstn       (rstn),
      .din_valid  (din_valid),
      .din_re     (din_re),
      .din_im     (din_im),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .dout_valid (dout_valid),
      .dout_sof   (dout_sof),
      .dout_sat   (dout_sat)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Returns the first lane value differing from exp, or exp if all match.
   function automatic int bus_val(input logic [DW-1:0][OW-1:0] bus, input int exp);
      for (int l = 0; l < DW; l++) begin
         if (int'($signed(bus[l])) != exp) return int'($signed(bus[l]));
      end
      return exp;
   endfunction

   task automatic drive(input bit v, input int re_v, input int im_v, input bit add_lane);
      din_valid = v;
      for (int l = 0; l < DW; l++) begin
         din_re[l] = IW'(re_v + (add_lane ? l : 0));
         din_im[l] = IW'(im_v - (add_lane ? l : 0));
      end
   endtask

   // Streams nf frames (vector value base+index) with optional idle cycles
   // and checks every output cycle against the expected interleaved order.
   task automatic run_stream(input int nf, input int base, input int idle_pct, input string tag);
      int  starts[4];
      int  sent;
      int  it;
      int  total;
      bit  done;
      bit  v;
      bit  exp_v;
      bit  exp_sof;
      int  exp_val;
      int  j;
      int  kk;
      sent  = 0;
      it    = 0;
      done  = 1'b0;
      total = nf * NV;
      for (int f = 0; f < 4; f++) starts[f] = -1;
      while (!done) begin
         v = 1'b0;
         if (sent < total) v = ($urandom_range(0, 99) >= idle_pct);
         if (v) drive(1'b1, 256 * (base + sent), -256 * (base + sent), 1'b1);
         else   drive(1'b0, 24'h5A5A5A, 24'h3C3C3C, 1'b0);
         step();
         if (v) begin
            if ((sent % NV) == NV - 1) starts[sent / NV] = it + 1;
            sent++;
         end
         exp_v   = 1'b0;
         exp_sof = 1'b0;
         exp_val = 0;
         for (int f = 0; f < nf; f++) begin
            if (starts[f] >= 0 && it >= starts[f] && it < starts[f] + NV) begin
               j       = it - starts[f];
               kk      = (j % 2) * (NV / 2) + j / 2;
               exp_v   = 1'b1;
               exp_sof = (j == 0);
               exp_val = base + f * NV + kk;
            end
         end
         chk($sformatf("%s_valid_c%0d", tag, it), int'(dout_valid), int'(exp_v));
         chk($sformatf("%s_sof_c%0d", tag, it), int'(dout_sof), int'(exp_sof));
         if (exp_v) begin
            chk($sformatf("%s_sat_c%0d", tag, it), int'(dout_sat), 0);
            hold_re = exp_val;
            hold_im = -exp_val;
         end
         chk($sformatf("%s_re_c%0d", tag, it), bus_val(dout_re, hold_re), hold_re);
         chk($sformatf("%s_im_c%0d", tag, it), bus_val(dout_im, hold_im), hold_im);
         it++;
         if (sent == total && it >= starts[nf-1] + NV + 2) done = 1'b1;
      end
      din_valid = 1'b0;
   endtask

   // One frame whose vector 0 carries a table row, remaining vectors zero.
   task automatic run_row(input rs_vec_t r, input int idx);
      int w;
      for (int k = 0; k < NV; k++) begin
         if (k == 0) drive(1'b1, r.a, r.b, 1'b0);
         else        drive(1'b1, 0, 0, 1'b0);
         step();
      end
      din_valid = 1'b0;
      w = 0;
      while (!dout_sof && w < 10) begin
         step();
         w++;
      end
      chk($sformatf("row%0d_latency", idx), w, 1);
      chk($sformatf("row%0d_re", idx), bus_val(dout_re, r.ya), r.ya);
      chk($sformatf("row%0d_im", idx), bus_val(dout_im, r.yb), r.yb);
      chk($sformatf("row%0d_sat", idx), int'(dout_sat), r.sat);
      repeat (NV) step();
      hold_re = 0;
      hold_im = 0;
   endtask

   initial begin
      tab[0] = '{a: 127,      b: 128,      ya: 0,      yb: 1,      sat: 0};
      tab[1] = '{a: -129,     b: -128,     ya: -1,     yb: 0,      sat: 0};
      tab[2] = '{a: 383,      b: 384,      ya: 1,      yb: 2,      sat: 0};
      tab[3] = '{a: 8388607,  b: -8388608, ya: 32767,  yb: -32768, sat: 1};
      tab[4] = '{a: -385,     b: -384,     ya: -2,     yb: -1,     sat: 0};
      tab[5] = '{a: 8388479,  b: 0,        ya: 32767,  yb: 0,      sat: 0};
      tab[6] = '{a: 8388480,  b: 0,        ya: 32767,  yb: 0,      sat: 1};

      // Reset state
      rstn = 1'b0;
      repeat (3) step();
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_sof", int'(dout_sof), 0);
      chk("rst_sat", int'(dout_sat), 0);
      chk("rst_re", bus_val(dout_re, 0), 0);
      chk("rst_im", bus_val(dout_im, 0), 0);
      rstn = 1'b1;
      step();

      // Single frame, back-to-back pair, frames with input gaps
      run_stream(1, 0, 0, "t1");
      run_stream(2, 0, 0, "t2");
      run_stream(1, 0, 30, "t3");
      run_stream(2, 64, 30, "t3b");

      // Rounding and saturation
      for (int i = 0; i < 7; i++) run_row(tab[i], i);

      // Leave a non-zero held output so the reset clear is observable
      run_stream(1, 10, 0, "pre");

      // Reset while vector 20 is being presented
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 256 * k, -256 * k, 1'b1);
         step();
      end
      drive(1'b1, 256 * 20, -256 * 20, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_in_valid", int'(dout_valid), 0);
      chk("rst_in_re", bus_val(dout_re, 0), 0);
      chk("rst_in_im", bus_val(dout_im, 0), 0);
      din_valid = 1'b0;
      repeat (2) step();
      rstn = 1'b1;
      hold_re = 0;
      hold_im = 0;
      repeat (2) step();
      chk("rst_in_idle_valid", int'(dout_valid), 0);

      // Reset in the middle of a readout
      for (int k = 0; k < NV; k++) begin
         drive(1'b1, 256 * (40 + k), -256 * (40 + k), 1'b1);
         step();
      end
      din_valid = 1'b0;
      repeat (6) step();
      chk("mid_rd_valid", int'(dout_valid), 1);
      rstn = 1'b0;
      #1;
      chk("rst_rd_valid", int'(dout_valid), 0);
      chk("rst_rd_sof", int'(dout_sof), 0);
      chk("rst_rd_re", bus_val(dout_re, 0), 0);
      chk("rst_rd_im", bus_val(dout_im, 0), 0);
      repeat (2) step();
      rstn = 1'b1;
      repeat (3) step();
      chk("rst_rd_idle_valid", int'(dout_valid), 0);
      chk("rst_rd_idle_re", bus_val(dout_re, 0), 0);

      // Next full frame after reset must match the first one exactly
      run_stream(1, 0, 0, "t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
